// File: rtl/avg_pkg.sv
// Shared types for the sample producer that feeds the four-sample averager.
package avg_pkg;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {IDLE, PRESENT, BUSY, GAP} snd_state_t;
endpackage

// File: rtl/sample_fifo.sv
// Small sample FIFO with registered full/empty and a combinational head read.
module sample_fifo
    import avg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = SAMPLE_W
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic         full_q, full_d, empty_q, empty_d, drop_q, drop_d;
    logic         wr_en, rd_en;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    always_comb begin
        rd_en   = pop && !empty_q;
        wr_en   = push && (!full_q || rd_en);
        wptr_d  = wptr_q + (AW+1)'(wr_en);
        rptr_d  = rptr_q + (AW+1)'(rd_en);
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
        drop_d  = push && !wr_en;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            drop_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;
    assign drop  = drop_q;
endmodule

// File: rtl/sample_sender.sv
// Presents buffered samples to the averager one at a time, paced by its modwait handshake.
module sample_sender
    import avg_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                push,
    input  logic [SAMPLE_W-1:0] push_data,
    output logic                full,
    output logic                empty,
    output logic                drop,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                data_ready,
    input  logic                modwait,
    input  logic                err,
    output logic [15:0]         sent_count,
    output logic                timeout,
    output logic                err_seen
);
    localparam int TW = $clog2(TIMEOUT + 1);

    snd_state_t          state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d, head;
    logic [15:0]         sent_q, sent_d;
    logic                timeout_q, timeout_d, err_seen_q, err_seen_d;
    logic                mw_q, pop;

    sample_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .wdata   (push_data),
        .pop     (pop),
        .rdata   (head),
        .full    (full),
        .empty   (empty),
        .drop    (drop)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sample_d   = sample_q;
        sent_d     = sent_q;
        timeout_d  = timeout_q;
        err_seen_d = err_seen_q | err;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                // Never hand a sample to an averager that is still busy.
                if (!empty && !modwait) begin
                    pop      = 1'b1;
                    sample_d = head;
                    timer_d  = '0;
                    state_d  = PRESENT;
                end
            end
            PRESENT: begin
                timer_d = timer_q + 1'b1;
                if (modwait) begin
                    state_d = BUSY;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = GAP;
                end
            end
            BUSY: begin
                if (mw_q && !modwait) begin
                    sent_d  = sent_q + 16'd1;
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            sample_q   <= '0;
            sent_q     <= '0;
            timeout_q  <= 1'b0;
            err_seen_q <= 1'b0;
            mw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sample_q   <= sample_d;
            sent_q     <= sent_d;
            timeout_q  <= timeout_d;
            err_seen_q <= err_seen_d;
            mw_q       <= modwait;
        end
    end

    assign data_ready  = (state_q == PRESENT);
    assign sample_data = sample_q;
    assign sent_count  = sent_q;
    assign timeout     = timeout_q;
    assign err_seen    = err_seen_q;
endmodule

// File: tb/tb_sample_sender.sv
// Directed bench for sample_sender with an averager-side responder and a sample scoreboard.
module tb_sample_sender;
    import avg_pkg::*;

    logic        clk = 1'b0, n_reset = 1'b0, push = 1'b0, modwait = 1'b0, err = 1'b0;
    logic [15:0] push_data = '0;
    logic        full, empty, drop, data_ready, timeout, err_seen;
    logic [15:0] sample_data, sent_count;

    sample_sender #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .push        (push),
        .push_data   (push_data),
        .full        (full),
        .empty       (empty),
        .drop        (drop),
        .sample_data (sample_data),
        .data_ready  (data_ready),
        .modwait     (modwait),
        .err         (err),
        .sent_count  (sent_count),
        .timeout     (timeout),
        .err_seen    (err_seen)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic [15:0] exp_q[$];
    int          mode = 0;      // 0 hold modwait low, 1 averager model, 2 hold high, 3 manual
    int          busy_cnt = 0;
    int          sum = 0, nsamp = 0;
    logic [15:0] last_avg = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Averager responder: raises modwait for 5 cycles each time it takes a sample.
    initial forever begin
        @(negedge clk);
        if (!n_reset) begin
            busy_cnt = 0;
            modwait  = 1'b0;
        end else begin
            case (mode)
                0: modwait = 1'b0;
                2: modwait = 1'b1;
                1: begin
                    if (busy_cnt > 0) begin
                        busy_cnt--;
                        if (busy_cnt == 0) modwait = 1'b0;
                    end else begin
                        modwait = 1'b0;
                        if (data_ready) begin
                            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                            if (exp_q.size() != 0) chk("sample", sample_data, exp_q.pop_front());
                            sum += int'(sample_data);
                            nsamp++;
                            if (nsamp % 4 == 0) begin
                                last_avg = 16'(sum / 4);
                                sum = 0;
                            end
                            modwait  = 1'b1;
                            busy_cnt = 5;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic push_one(input logic [15:0] v, input logic exp_drop);
        @(negedge clk);
        push = 1'b1;
        push_data = v;
        @(negedge clk);
        push = 1'b0;
        chk("drop", drop, exp_drop);
        if (!exp_drop) exp_q.push_back(v);
    endtask

    task automatic wait_sent(input logic [15:0] target, input string tag);
        for (int i = 0; i < 600 && !(sent_count == target && exp_q.size() == 0
                                      && !modwait && !data_ready); i++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        chk(tag, sent_count, target);
        chk({tag, "_empty"}, empty, 1'b1);
    endtask

    initial begin
        int len;
        repeat (2) @(negedge clk);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_drop", drop, 1'b0);
        chk("rst_ready", data_ready, 1'b0);
        chk("rst_sample", sample_data, 16'h0);
        chk("rst_sent", sent_count, 16'h0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_errseen", err_seen, 1'b0);
        n_reset = 1'b1;

        // 1: four samples through the averager handshake, in order
        mode = 1;
        push_one(16'h0004, 1'b0);
        push_one(16'h0008, 1'b0);
        push_one(16'h000C, 1'b0);
        push_one(16'h0010, 1'b0);
        wait_sent(16'd4, "t1_sent");

        // 2: overfill while the averager is busy; fifth push is dropped
        mode = 2;
        repeat (2) @(negedge clk);
        push_one(16'h0001, 1'b0);
        push_one(16'h0002, 1'b0);
        push_one(16'h0003, 1'b0);
        push_one(16'h0004, 1'b0);
        chk("t2_full", full, 1'b1);
        push_one(16'h0005, 1'b1);
        @(negedge clk);
        chk("t2_drop_pulse", drop, 1'b0);
        chk("t2_full_hold", full, 1'b1);
        mode = 1;
        wait_sent(16'd8, "t2_sent");

        // 3: no handshake -> timeout after 16 cycles of data_ready
        mode = 0;
        push_one(16'h0AAA, 1'b0);
        for (int i = 0; i < 20 && !data_ready; i++) @(negedge clk);
        chk("t3_sample", sample_data, exp_q.pop_front());
        len = 0;
        while (data_ready && len < 40) begin
            len++;
            @(negedge clk);
        end
        chk("t3_ready_len", len, 16);
        chk("t3_timeout", timeout, 1'b1);
        chk("t3_sent", sent_count, 16'd8);
        mode = 1;
        push_one(16'h0BBB, 1'b0);
        wait_sent(16'd9, "t3_after");
        chk("t3_timeout_sticky", timeout, 1'b1);

        // 4: full FIFO, push coincident with the IDLE pop -> accepted
        mode = 2;
        repeat (2) @(negedge clk);
        push_one(16'h0101, 1'b0);
        push_one(16'h0202, 1'b0);
        push_one(16'h0303, 1'b0);
        push_one(16'h0404, 1'b0);
        @(negedge clk);
        mode = 3;
        @(negedge clk);
        modwait = 1'b0;
        push = 1'b1;
        push_data = 16'h0505;
        @(negedge clk);
        push = 1'b0;
        exp_q.push_back(16'h0505);
        chk("t4_drop", drop, 1'b0);
        chk("t4_full", full, 1'b1);
        chk("t4_ready", data_ready, 1'b1);
        mode = 1;
        wait_sent(16'd14, "t4_sent");

        // 5: reset in BUSY with a sample still queued
        push_one(16'h0C0C, 1'b0);
        push_one(16'h0D0D, 1'b0);
        for (int i = 0; i < 40 && !(modwait && !data_ready); i++) @(negedge clk);
        n_reset = 1'b0;
        #1;
        chk("t5_ready", data_ready, 1'b0);
        chk("t5_empty", empty, 1'b1);
        chk("t5_sent", sent_count, 16'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        push_one(16'h0E0E, 1'b0);
        wait_sent(16'd1, "t5_after");

        // 6: four equal samples average to the same value
        sum = 0;
        nsamp = 0;
        repeat (4) push_one(16'h0100, 1'b0);
        wait_sent(16'd5, "t6_sent");
        chk("t6_avg", last_avg, 16'h0100);
        chk("t6_errseen", err_seen, 1'b0);

        // err is captured sticky
        @(negedge clk);
        err = 1'b1;
        @(negedge clk);
        err = 1'b0;
        chk("err_seen_set", err_seen, 1'b1);
        repeat (3) @(negedge clk);
        chk("err_seen_sticky", err_seen, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
